apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 102 ++++++++++
 tb/tb_apb_req_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one APB completer.
// Each grant runs SETUP then ACCESS; ACCESS is aborted after TIMEOUT cycles without pready.
module apb_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   req_write,
   input  logic [8*NUM_REQ-1:0] req_addr,
   input  logic [8*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic                 err,
   output logic [7:0]           rdata,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [7:0]           paddr,
   output logic [7:0]           pwdata,
   input  logic [7:0]           prdata,
   input  logic                 pready
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t             state, state_nxt;
   logic [IW-1:0]      last_idx, win_idx;
   logic               win_found, take, complete, timeout_hit;
   logic [NUM_REQ-1:0] cand;
   logic [7:0]         wait_cnt;

   assign timeout_hit = (wait_cnt == 8'(TIMEOUT-1));
   assign complete    = (state == ACCESS) && (pready || timeout_hit);
   // The finishing owner is excluded so it cannot immediately win again.
   assign cand        = req & ~((state == ACCESS) ? gnt : '0);
   assign take        = win_found && ((state == IDLE) || complete);

   assign psel    = (state != IDLE);
   assign penable = (state == ACCESS);
   assign done    = complete ? gnt : '0;
   assign err     = complete && !pready;

   // Scan from farthest to nearest so the nearest candidate after last_idx wins.
   always_comb begin : rr_pick
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last_idx) + k) % NUM_REQ;
         if (cand[idx]) begin
            win_found = 1'b1;
            win_idx   = IW'(idx);
         end
      end
   end

   always_comb begin : next_state
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (complete) state_nxt = win_found ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         last_idx <= IW'(NUM_REQ-1);
         wait_cnt <= '0;
         rdata    <= '0;
         pwrite   <= 1'b0;
         paddr    <= '0;
         pwdata   <= '0;
      end else begin
         state <= state_nxt;
         if (state == SETUP)
            wait_cnt <= '0;
         else if ((state == ACCESS) && !pready)
            wait_cnt <= wait_cnt + 8'd1;
         if (complete && pready && !pwrite)
            rdata <= prdata;
         if (complete)
            gnt <= '0;
         if (take) begin
            gnt      <= NUM_REQ'(1) << win_idx;
            last_idx <= win_idx;
            pwrite   <= req_write[win_idx];
            paddr    <= req_addr[win_idx*8 +: 8];
            pwdata   <= req_wdata[win_idx*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transfer-level model.
module tb_apb_req_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;
   localparam int AW = 8*N;

   logic           clk, rst;
   logic [N-1:0]   req, req_write, gnt, done;
   logic [AW-1:0]  req_addr, req_wdata;
   logic           err, psel, penable, pwrite, pready;
   logic [7:0]     rdata, paddr, pwdata, prdata;

   apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
      .err(err), .rdata(rdata), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: owner (-1 = idle), position within transfer (0 = setup, k = k-th access cycle)
   int           m_owner, m_pos, m_last;
   logic         m_wr, m_have;
   logic [7:0]   m_addr, m_wd, m_rdata;
   logic [N-1:0] exp_done = '0;

   function automatic int pick(input logic [N-1:0] r, input int mask);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (m_last + k) % N;
         if (r[i] && i != mask) return i;
      end
      return -1;
   endfunction

   task automatic grant(input int w);
      m_owner = w;
      m_pos   = 0;
      m_last  = w;
      m_wr    = req_write[w];
      m_addr  = req_addr[8*w +: 8];
      m_wd    = req_wdata[8*w +: 8];
      m_have  = 1'b1;
   endtask

   always @(negedge clk) begin : model_check
      logic [N-1:0] e_gnt, e_done;
      logic         e_cmp;
      int           w;
      if (rst) begin
         m_owner = -1; m_pos = 0; m_last = N-1; m_rdata = 8'h00; m_have = 1'b0;
      end
      e_gnt    = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_cmp    = (m_owner >= 0) && (m_pos >= 1) && (pready || m_pos == TO);
      e_done   = e_cmp ? e_gnt : '0;
      exp_done = e_done;
      chk("m_psel",    psel,    m_owner >= 0);
      chk("m_penable", penable, (m_owner >= 0) && (m_pos >= 1));
      chk("m_gnt",     gnt,     e_gnt);
      chk("m_done",    done,    e_done);
      chk("m_err",     err,     e_cmp && !pready);
      chk("m_rdata",   rdata,   m_rdata);
      if (m_have) begin
         chk("m_paddr",  paddr,  m_addr);
         chk("m_pwdata", pwdata, m_wd);
         chk("m_pwrite", pwrite, m_wr);
      end
      if (!rst) begin
         if (m_owner < 0) begin
            w = pick(req, -1);
            if (w >= 0) grant(w);
         end else if (m_pos == 0) begin
            m_pos = 1;
         end else if (e_cmp) begin
            if (!m_wr && pready) m_rdata = prdata;
            w = pick(req, m_owner);
            m_owner = -1;
            m_pos   = 0;
            if (w >= 0) grant(w);
         end else begin
            m_pos++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d);
      req_write[i]      = wr;
      req_addr[8*i +: 8]  = a;
      req_wdata[8*i +: 8] = d;
      req[i]            = 1'b1;
   endtask

   initial begin
      int  n;
      logic got, stall;
      rst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      pready = 1'b0; prdata = 8'h00;
      repeat (2) tick();
      chk("rst_psel", psel, 0); chk("rst_penable", penable, 0);
      chk("rst_gnt", gnt, 0);   chk("rst_done", done, 0);
      chk("rst_err", err, 0);   chk("rst_rdata", rdata, 8'h00);
      rst = 1'b0;

      // single write to requester 1, zero wait states
      set_req(1, 1'b1, 8'h20, 8'h5A); pready = 1'b1;
      tick(); @(negedge clk);
      chk("wr_setup_psel", psel, 1); chk("wr_setup_pen", penable, 0); chk("wr_setup_gnt", gnt, 4'b0010);
      tick(); @(negedge clk);
      chk("wr_done", done, 4'b0010); chk("wr_err", err, 0);
      chk("wr_paddr", paddr, 8'h20); chk("wr_pwdata", pwdata, 8'h5A); chk("wr_pwrite", pwrite, 1);
      tick(); req = '0; @(negedge clk);
      chk("wr_idle_psel", psel, 0); chk("wr_idle_gnt", gnt, 0);

      // read from requester 0 with three wait states
      set_req(0, 1'b0, 8'h10, 8'h00); pready = 1'b0;
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("rd_wait_done", done, 0);
         tick();
      end
      pready = 1'b1; prdata = 8'hC3;
      @(negedge clk); chk("rd_done", done, 4'b0001); chk("rd_err", err, 0); chk("rd_paddr", paddr, 8'h10);
      tick(); req = '0; pready = 1'b0; prdata = 8'h00;
      @(negedge clk); chk("rd_rdata", rdata, 8'hC3);

      // timeout on a read from requester 3
      set_req(3, 1'b0, 8'h33, 8'h00); prdata = 8'hEE;
      tick();
      n = 0; got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         tick(); @(negedge clk);
         if (penable) n++;
         if (done != 0) begin
            got = 1'b1;
            chk("to_done", done, 4'b1000); chk("to_err", err, 1);
         end
      end
      chk("to_seen", got, 1); chk("to_len", n, TO);
      tick(); req = '0;
      @(negedge clk); chk("to_rdata", rdata, 8'hC3);

      // reset in the middle of an ACCESS phase
      set_req(2, 1'b0, 8'h44, 8'h00);
      tick(); tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_psel", psel, 0); chk("arst_penable", penable, 0);
      chk("arst_gnt", gnt, 0);   chk("arst_done", done, 0);
      tick();
      set_req(0, 1'b0, 8'h55, 8'h00);
      rst = 1'b0;
      tick(); @(negedge clk); chk("arst_first", gnt, 4'b0001);

      // randomized traffic, including stalls long enough to time out
      stall = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (exp_done[i] && $urandom_range(3) != 0) req[i] = 1'b0;
            else if (!req[i] && $urandom_range(2) == 0) req[i] = 1'b1;
            else if (req[i] && $urandom_range(40) == 0) req[i] = 1'b0;
         end
         req_write = N'($urandom);
         req_addr  = AW'($urandom);
         req_wdata = AW'($urandom);
         if ($urandom_range(60) == 0) stall = !stall;
         pready = stall ? 1'b0 : ($urandom_range(2) == 0);
         prdata = 8'($urandom);
      end
      req = '0;
      repeat (40) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
